// File: rtl/accel_tx_sequencer.sv
// Packs one accelerometer sample into an 8-byte UART frame (header, X, Y, Z big-endian, checksum),
// paces bytes on the transmitter's done tick, guards each byte with a timeout and idles P_GAP cycles after.
module accel_tx_sequencer #(
   parameter logic [7:0] P_HEADER  = 8'hA5,
   parameter int         P_GAP     = 16,
   parameter int         P_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid_i,
   input  logic [15:0] acc_x_i,
   input  logic [15:0] acc_y_i,
   input  logic [15:0] acc_z_i,
   input  logic        tx_done_tick_i,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic [7:0]  drop_cnt_o,
   output logic        timeout_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   localparam logic [15:0] TMO_LAST = 16'(P_TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST = 16'((P_GAP > 0) ? (P_GAP - 1) : 0);
   // With no gap configured the frame ends straight back in idle.
   localparam logic [1:0]  S_AFTER  = (P_GAP > 0) ? S_GAP : S_IDLE;

   logic [1:0]  state;
   logic [2:0]  idx;
   logic [15:0] tmr;
   logic [15:0] gap_cnt;
   logic [7:0]  data_q;
   logic [15:0] x_q;
   logic [15:0] y_q;
   logic [15:0] z_q;

   function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [15:0] x,
                                             input logic [15:0] y, input logic [15:0] z);
      logic [7:0] csum;
      csum = P_HEADER + x[15:8] + x[7:0] + y[15:8] + y[7:0] + z[15:8] + z[7:0];
      case (i)
         3'd0:    frame_byte = P_HEADER;
         3'd1:    frame_byte = x[15:8];
         3'd2:    frame_byte = x[7:0];
         3'd3:    frame_byte = y[15:8];
         3'd4:    frame_byte = y[7:0];
         3'd5:    frame_byte = z[15:8];
         3'd6:    frame_byte = z[7:0];
         default: frame_byte = csum;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         idx           <= 3'd0;
         tmr           <= 16'd0;
         gap_cnt       <= 16'd0;
         data_q        <= 8'h00;
         x_q           <= 16'd0;
         y_q           <= 16'd0;
         z_q           <= 16'd0;
         frame_done_o  <= 1'b0;
         drop_cnt_o    <= 8'd0;
         timeout_err_o <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         if (sample_valid_i && (state != S_IDLE))
            drop_cnt_o <= sat_inc(drop_cnt_o);

         case (state)
            S_IDLE: begin
               if (sample_valid_i) begin
                  x_q    <= acc_x_i;
                  y_q    <= acc_y_i;
                  z_q    <= acc_z_i;
                  idx    <= 3'd0;
                  data_q <= P_HEADER;
                  state  <= S_SEND;
               end
            end
            S_SEND: begin
               tmr   <= 16'd0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_done_tick_i) begin
                  if (idx == 3'd7) begin
                     frame_done_o <= 1'b1;
                     gap_cnt      <= 16'd0;
                     state        <= S_AFTER;
                  end else begin
                     idx    <= idx + 3'd1;
                     data_q <= frame_byte(idx + 3'd1, x_q, y_q, z_q);
                     state  <= S_SEND;
                  end
               end else if (tmr == TMO_LAST) begin
                  // Byte never completed: drop the rest of the frame, remember the fault.
                  timeout_err_o <= 1'b1;
                  gap_cnt       <= 16'd0;
                  state         <= S_AFTER;
               end else begin
                  tmr <= tmr + 16'd1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST)
                  state <= S_IDLE;
               else
                  gap_cnt <= gap_cnt + 16'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign tx_start_o = (state == S_SEND);
   assign busy_o     = (state != S_IDLE);
   assign tx_data_o  = data_q;

endmodule

// File: tb/tb_accel_tx_sequencer.sv
// Bench for accel_tx_sequencer: table of sample vectors with expected checksums, a byte scoreboard
// fed at stimulus time, a UART done-tick model, and hand sequences for drop, timeout, reset and zero-gap.
module tb_accel_tx_sequencer;

   localparam int GAP = 16;
   localparam int TMO = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sv, done, start, busy, fdone, terr;
   logic [15:0] ax, ay, az;
   logic [7:0]  data, dropc;
   logic        sv0, done0, start0, busy0, fdone0, terr0;
   logic [15:0] ax0, ay0, az0;
   logic [7:0]  data0, dropc0;

   always #5 clk = ~clk;

   accel_tx_sequencer #(.P_HEADER(8'hA5), .P_GAP(GAP), .P_TIMEOUT(TMO)) u_dut (
      .clk(clk), .rst_n(rst_n), .sample_valid_i(sv),
      .acc_x_i(ax), .acc_y_i(ay), .acc_z_i(az), .tx_done_tick_i(done),
      .tx_start_o(start), .tx_data_o(data), .busy_o(busy), .frame_done_o(fdone),
      .drop_cnt_o(dropc), .timeout_err_o(terr));

   accel_tx_sequencer #(.P_HEADER(8'hA5), .P_GAP(0), .P_TIMEOUT(64)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sample_valid_i(sv0),
      .acc_x_i(ax0), .acc_y_i(ay0), .acc_z_i(az0), .tx_done_tick_i(done0),
      .tx_start_o(start0), .tx_data_o(data0), .busy_o(busy0), .frame_done_o(fdone0),
      .drop_cnt_o(dropc0), .timeout_err_o(terr0));

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [7:0]  csum;
      int          dly;
   } vec_t;
   vec_t vecs[5];

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] sb[$];
   int   it = 0, nbyte = 0, pend = -1, s_it = 0, gap_start = -1;
   int   frames = 0, starts = 0, stab_err = 0, uart_dly = 100;
   logic waiting = 1'b0, pbusy = 1'b0, terr_model = 1'b0, tmo_seen = 1'b0, withhold = 1'b0;
   logic [7:0] last_data = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // UART model and output monitor, sampled 1 time unit after each rising edge.
   initial begin
      logic pd, exp_st, exp_fd;
      logic [7:0] e;
      forever begin
         @(posedge clk); #1;
         it++;
         pd = done;
         done = 1'b0;
         if (!rst_n) begin
            nbyte = 0; pend = -1; waiting = 1'b0; gap_start = -1; terr_model = 1'b0;
            pbusy = busy;
         end else begin
            exp_st = 1'b0;
            exp_fd = 1'b0;
            if (pd && waiting) begin
               waiting = 1'b0;
               if (nbyte < 8) exp_st = 1'b1;
               else exp_fd = 1'b1;
            end
            if (sv && !pbusy) begin
               exp_st = 1'b1;
               nbyte = 0;
            end
            if (waiting && pend < 0) begin
               if (it == s_it + TMO) chk("timeout_not_early", terr, terr_model);
               else if (it == s_it + TMO + 1) begin
                  chk("timeout_flag", terr, 1);
                  chk("timeout_to_gap", busy, 1);
                  terr_model = 1'b1; waiting = 1'b0; tmo_seen = 1'b1; gap_start = it;
               end
            end
            if (waiting && !start && data !== last_data) stab_err++;
            if (exp_st || start) chk("start_timing", start, exp_st);
            if (exp_fd || fdone) chk("frame_done", fdone, exp_fd);
            if (exp_fd) begin
               frames++;
               gap_start = it;
            end
            if (start) begin
               nbyte++;
               starts++;
               if (sb.size() == 0) begin
                  n_chk++;
                  $display("FAIL sb_underflow: byte %0h sent, expected no byte", data);
               end else begin
                  e = sb.pop_front();
                  chk("tx_byte", data, e);
               end
               last_data = data;
               waiting = 1'b1;
               s_it = it;
               pend = (withhold && nbyte == 4) ? -1 : uart_dly;
            end else if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  done = 1'b1;
                  pend = -1;
               end
            end
            if (pbusy && !busy && gap_start >= 0) begin
               chk("gap_length", it - gap_start, GAP);
               gap_start = -1;
            end
            pbusy = busy;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push_frame(input int k);
      sb.push_back(8'hA5);
      sb.push_back(vecs[k].x[15:8]); sb.push_back(vecs[k].x[7:0]);
      sb.push_back(vecs[k].y[15:8]); sb.push_back(vecs[k].y[7:0]);
      sb.push_back(vecs[k].z[15:8]); sb.push_back(vecs[k].z[7:0]);
      sb.push_back(vecs[k].csum);
   endtask

   task automatic pulse_sample(input int k, input bit push);
      ax = vecs[k].x; ay = vecs[k].y; az = vecs[k].z;
      sv = 1'b1;
      if (push) push_frame(k);
      @(negedge clk);
      sv = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         n_chk++;
         $display("FAIL idle_wait: still busy after %0d cycles, expected idle", lim);
      end
   endtask

   task automatic wait_frames(input int target, input int lim);
      int n = 0;
      while (frames < target && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("frames_seen", frames, target);
   endtask

   task automatic run_gap0();
      int nb = 0, pnd = -1, fr = 0, last = -10;
      logic pd;
      ax0 = vecs[0].x; ay0 = vecs[0].y; az0 = vecs[0].z;
      sv0 = 1'b1;
      for (int i = 0; i < 400 && fr < 3; i++) begin
         @(posedge clk); #1;
         pd = done0;
         done0 = 1'b0;
         if (pd && nb == 8) begin
            chk("gap0_idle_after_done", busy0, 0);
            chk("gap0_frame_done", fdone0, 1);
            nb = 0; fr++; last = i;
         end else if (i == last + 1) begin
            chk("gap0_b2b_start", start0, 1);
            chk("gap0_b2b_header", data0, 8'hA5);
         end
         if (start0) begin
            nb++;
            pnd = 2;
         end else if (pnd > 0) begin
            pnd--;
            if (pnd == 0) begin
               done0 = 1'b1;
               pnd = -1;
            end
         end
      end
      chk("gap0_frames", fr, 3);
      chk("gap0_no_timeout", terr0, 0);
      chk("gap0_drops_counted", (dropc0 != 8'd0), 1);
      @(negedge clk);
      sv0 = 1'b0;
   endtask

   initial begin
      int f0, n;
      vecs[0] = '{16'h1234, 16'hABCD, 16'h00FF, 8'h62, 100};
      vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 8'hA5, 5};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h9F, 5};
      vecs[3] = '{16'h0102, 16'h0304, 16'h0506, 8'hBA, 5};
      vecs[4] = '{16'h8000, 16'h7FFF, 16'h005B, 8'hFE, 5};
      rst_n = 1'b0; sv = 1'b0; done = 1'b0; ax = '0; ay = '0; az = '0;
      sv0 = 1'b0; done0 = 1'b0; ax0 = '0; ay0 = '0; az0 = '0;

      repeat (3) @(negedge clk);
      chk("rst_start", start, 0); chk("rst_data", data, 8'h00); chk("rst_busy", busy, 0);
      chk("rst_frame_done", fdone, 0); chk("rst_drop", dropc, 0); chk("rst_timeout", terr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 5; k++) begin
         wait_idle(100);
         uart_dly = vecs[k].dly; starts = 0; f0 = frames;
         pulse_sample(k, 1'b1);
         wait_frames(f0 + 1, 2000);
         chk("frame_starts", starts, 8);
         chk("sb_drained", sb.size(), 0);
         chk("no_timeout", terr, 0);
      end

      // Drops during a frame and during the gap leave the latched sample alone.
      wait_idle(100);
      uart_dly = 5; f0 = frames;
      pulse_sample(3, 1'b1);
      repeat (3) @(negedge clk);
      pulse_sample(1, 1'b0);
      repeat (10) @(negedge clk);
      pulse_sample(2, 1'b0);
      repeat (15) @(negedge clk);
      pulse_sample(4, 1'b0);
      wait_frames(f0 + 1, 500);
      @(negedge clk);
      chk("gap_busy", busy, 1);
      pulse_sample(0, 1'b0);
      wait_idle(100);
      chk("drop_cnt_4", dropc, 4);
      chk("drop_sb_drained", sb.size(), 0);

      // Byte 3 never completes.
      withhold = 1'b1; tmo_seen = 1'b0; f0 = frames; uart_dly = 5;
      pulse_sample(2, 1'b1);
      n = 0;
      while (!tmo_seen && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_seen", tmo_seen, 1);
      sb.delete();
      withhold = 1'b0;
      chk("timeout_no_frame_done", frames, f0);
      wait_idle(100);
      starts = 0;
      pulse_sample(4, 1'b1);
      wait_frames(f0 + 1, 1000);
      chk("after_tmo_starts", starts, 8);
      chk("timeout_sticky", terr, 1);
      chk("after_tmo_sb_drained", sb.size(), 0);

      // Reset while waiting on byte 4.
      wait_idle(100);
      uart_dly = 100;
      pulse_sample(0, 1'b1);
      n = 0;
      while (!(nbyte == 5 && waiting && it >= s_it + 2) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_byte4_wait", nbyte, 5);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_start", start, 0); chk("mid_rst_data", data, 8'h00);
      chk("mid_rst_busy", busy, 0); chk("mid_rst_frame_done", fdone, 0);
      chk("mid_rst_drop", dropc, 0); chk("mid_rst_timeout", terr, 0);
      rst_n = 1'b1;
      sb.delete();
      done = 1'b1;
      @(negedge clk);
      chk("stray_done_start", start, 0);
      chk("stray_done_busy", busy, 0);
      starts = 0; f0 = frames;
      pulse_sample(0, 1'b1);
      wait_frames(f0 + 1, 2000);
      chk("after_rst_starts", starts, 8);
      chk("after_rst_sb_drained", sb.size(), 0);

      // Valid held for 301 cycles: one accept, 300 drops.
      wait_idle(100);
      uart_dly = 100; f0 = frames;
      ax = vecs[4].x; ay = vecs[4].y; az = vecs[4].z;
      sv = 1'b1;
      push_frame(4);
      repeat (301) @(negedge clk);
      sv = 1'b0;
      chk("drop_saturate", dropc, 255);
      wait_frames(f0 + 1, 2000);
      chk("sat_sb_drained", sb.size(), 0);

      run_gap0();

      chk("data_stable_while_waiting", stab_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/accel_tx_sequencer.md
ACCEL_TX_SEQUENCER -- requirements
Module: accel_tx_sequencer

Interface
REQ-001 Parameter P_HEADER, default 8'hA5, first byte of every frame.
REQ-002 Parameter P_GAP, default 16, idle clock cycles inserted after each frame (0 = none).
REQ-003 Parameter P_TIMEOUT, default 1024, max cycles waited for tx_done_tick_i per byte (range 2..65535).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 sample_valid_i  input  1  one-cycle strobe, acc_x/y/z_i valid.
REQ-007 acc_x_i, acc_y_i, acc_z_i  input  16 each  accelerometer axis samples.
REQ-008 tx_done_tick_i  input  1  byte-complete pulse from UART transmitter.
REQ-009 tx_start_o  output  1  one-cycle send command to UART transmitter.
REQ-010 tx_data_o  output  8  byte to transmit.
REQ-011 busy_o  output  1  high whenever state is not S_IDLE.
REQ-012 frame_done_o  output  1  one-cycle pulse after a full frame is sent.
REQ-013 drop_cnt_o  output  8  count of rejected samples, saturating.
REQ-014 timeout_err_o  output  1  sticky flag, a byte timed out.

Function
REQ-015 Frame SHALL be 8 bytes in order: P_HEADER, x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0], checksum.
REQ-016 Checksum SHALL be the sum of bytes 0..6 modulo 256 (carries discarded).
REQ-017 FSM states SHALL be S_IDLE, S_SEND, S_WAIT, S_GAP.
REQ-018 S_IDLE: on sample_valid_i=1, latch all three axes, byte index=0, go to S_SEND; otherwise stay.
REQ-019 S_SEND: tx_start_o=1 for exactly this one cycle, with tx_data_o = byte[index]; next state S_WAIT, timeout counter cleared.
REQ-020 Latency: sample_valid_i accepted in cycle N gives tx_start_o=1 with tx_data_o=P_HEADER in cycle N+1.
REQ-021 tx_data_o SHALL stay stable from the S_SEND cycle until tx_done_tick_i is received or a timeout occurs.
REQ-022 S_WAIT: on tx_done_tick_i=1 with index<7, increment index and go to S_SEND, so the next start comes one cycle after the done tick.
REQ-023 S_WAIT: on tx_done_tick_i=1 with index=7, pulse frame_done_o in the next cycle and go to S_GAP (or S_IDLE if P_GAP=0).
REQ-024 S_WAIT: if P_TIMEOUT cycles elapse without tx_done_tick_i, set timeout_err_o=1, abandon the frame (no frame_done_o), and go to S_GAP (or S_IDLE if P_GAP=0).
REQ-025 tx_done_tick_i outside S_WAIT SHALL be ignored.
REQ-026 S_GAP: count P_GAP cycles, then go to S_IDLE; samples are not accepted in S_GAP.
REQ-027 sample_valid_i in any state other than S_IDLE SHALL be dropped.
- Latched data is unchanged by a dropped sample.
- drop_cnt_o increments by 1 per drop and saturates at 255.
REQ-028 Sample capture SHALL occur only in S_IDLE; a sample in the first S_IDLE cycle after S_GAP is accepted.
REQ-029 timeout_err_o SHALL stay set until reset.
REQ-030 busy_o SHALL be a registered or combinational decode of state; it is low in exactly the cycles where a sample would be accepted.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force:
- state S_IDLE, index 0, timers 0;
- tx_start_o=0, tx_data_o=8'h00, frame_done_o=0, drop_cnt_o=0, timeout_err_o=0, busy_o=0;
- latched samples cleared.
REQ-032 Reset mid-frame SHALL abort the frame with no further tx_start_o pulses; the first sample after rst_n rises starts a fresh frame at byte 0.

Verification
REQ-033 x=16'h1234, y=16'hABCD, z=16'h00FF, with the UART model returning done 100 cycles after each start -> bytes A5,12,34,AB,CD,00,FF,62 in order, 8 start pulses, one frame_done_o, timeout_err_o=0.
REQ-034 Latency check: sample in cycle N -> tx_start_o in N+1; done tick in cycle M -> next tx_start_o in M+1.
REQ-035 Three sample_valid_i pulses during a frame plus one during S_GAP -> drop_cnt_o=4, frame contents equal to the first sample; 300 drops -> drop_cnt_o=255.
REQ-036 UART model withholds done on byte 3 -> timeout_err_o=1 after P_TIMEOUT cycles, no frame_done_o, return to S_IDLE after P_GAP, next sample produces a complete frame with timeout_err_o still 1.
REQ-037 rst_n=0 during S_WAIT of byte 4 -> all outputs at reset values next cycle, stray done tick ignored, next sample starts with P_HEADER.
REQ-038 P_GAP=0 build: sample_valid_i held high continuously -> back-to-back frames with exactly one idle cycle between last done tick and next header start.
